// File: rtl/riscv_pkg.sv
// Shared definitions for the UART memory loader: FSM encoding, header length
// and the word address helper.
package riscv_pkg;

  typedef enum logic [2:0] {
    StHdr   = 3'd0,
    StData  = 3'd1,
    StWrite = 3'd2,
    StDone  = 3'd3,
    StErr   = 3'd4
  } loader_state_e;

  // Bytes in the word-count header (and in every data word).
  localparam int unsigned HdrBytes = 4;

  // Byte address of a word; wraps at 32 bits.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/uart_mem_loader.sv
// UART memory loader.
// Receives a frame of a 4-byte little-endian word count N followed by N words
// (4 bytes each, little-endian) and writes each word to data memory while
// holding the CPU in reset. The CPU is released once the image is loaded.
//
// Ports:
//   clk            - rising-edge clock
//   reset          - asynchronous active-low reset
//   rx_valid       - one-cycle strobe, rx_data holds a received byte
//   rx_data        - received byte
//   cpu_reset      - active-high CPU reset, low only once loading is done
//   Ext_MemWrite   - one-cycle word write strobe
//   Ext_WriteData  - assembled word (zero outside the write cycle)
//   Ext_DataAdr    - word byte address (zero outside the write cycle)
//   load_done      - image loaded, CPU released
//   load_err       - sticky illegal word count flag
module uart_mem_loader
  import riscv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 64,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        cpu_reset,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  output logic        load_done,
  output logic        load_err
);

  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
  localparam logic [IdleW-1:0] IdleMax  = IdleW'(TIMEOUT);
  // The timeout fires on the edge that ends the TIMEOUT-th idle cycle.
  localparam logic [IdleW-1:0] IdleFire = IdleW'(TIMEOUT - 1);
  localparam logic [1:0] LastByte = 2'(HdrBytes - 1);

  loader_state_e    state_q, state_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [15:0]      word_idx_q, word_idx_d;
  logic [15:0]      count_q, count_d;
  logic [31:0]      shreg_q, shreg_d;
  logic             mem_write_q, mem_write_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      adr_q, adr_d;
  logic             load_err_q, load_err_d;
  logic [IdleW-1:0] idle_q, idle_d;

  logic [31:0] shifted;
  logic [15:0] word_idx_inc;
  logic        in_frame;
  logic        timeout;

  // Header and data share one shift register, filled LSB first.
  assign shifted      = {rx_data, shreg_q[31:8]};
  assign word_idx_inc = word_idx_q + 16'd1;
  assign in_frame     = ((state_q == StHdr) && (byte_idx_q != 2'd0)) || (state_q == StData);
  assign timeout      = in_frame && !rx_valid && (idle_q >= IdleFire);

  // Idle counter: clears on every byte, saturates otherwise.
  always_comb begin
    idle_d = idle_q;
    if (rx_valid) begin
      idle_d = '0;
    end else if (idle_q != IdleMax) begin
      idle_d = idle_q + IdleW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    word_idx_d  = word_idx_q;
    count_d     = count_q;
    shreg_d     = shreg_q;
    load_err_d  = load_err_q;
    mem_write_d = 1'b0;
    wdata_d     = '0;
    adr_d       = '0;

    unique case (state_q)
      StHdr: begin
        if (timeout) begin
          byte_idx_d = '0;
          word_idx_d = '0;
          count_d    = '0;
          shreg_d    = '0;
        end else if (rx_valid) begin
          if (byte_idx_q == LastByte) begin
            byte_idx_d = '0;
            word_idx_d = '0;
            shreg_d    = '0;
            // Full 32-bit count is checked so high bytes cannot alias to a legal N.
            if (shifted == 32'd0) begin
              state_d = StDone;
            end else if (shifted > 32'(MAX_WORDS)) begin
              state_d    = StErr;
              load_err_d = 1'b1;
            end else begin
              count_d = shifted[15:0];
              state_d = StData;
            end
          end else begin
            shreg_d    = shifted;
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      StData: begin
        if (timeout) begin
          state_d    = StHdr;
          byte_idx_d = '0;
          word_idx_d = '0;
          count_d    = '0;
          shreg_d    = '0;
        end else if (rx_valid) begin
          if (byte_idx_q == LastByte) begin
            mem_write_d = 1'b1;
            wdata_d     = shifted;
            adr_d       = word_addr(BASE_ADDR, word_idx_q);
            shreg_d     = '0;
            byte_idx_d  = '0;
            state_d     = StWrite;
          end else begin
            shreg_d    = shifted;
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      StWrite: begin
        word_idx_d = word_idx_inc;
        if (word_idx_inc == count_q) begin
          state_d = StDone;
        end else begin
          state_d = StData;
          // A byte landing in the write cycle starts the next word.
          if (rx_valid) begin
            shreg_d    = shifted;
            byte_idx_d = 2'd1;
          end
        end
      end

      StDone, StErr: begin
        // Absorbing until reset; incoming bytes are dropped.
      end

      default: begin
        state_d = StHdr;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StHdr;
      byte_idx_q  <= '0;
      word_idx_q  <= '0;
      count_q     <= '0;
      shreg_q     <= '0;
      mem_write_q <= 1'b0;
      wdata_q     <= '0;
      adr_q       <= '0;
      load_err_q  <= 1'b0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      word_idx_q  <= word_idx_d;
      count_q     <= count_d;
      shreg_q     <= shreg_d;
      mem_write_q <= mem_write_d;
      wdata_q     <= wdata_d;
      adr_q       <= adr_d;
      load_err_q  <= load_err_d;
      idle_q      <= idle_d;
    end
  end

  assign cpu_reset     = (state_q != StDone);
  assign load_done     = (state_q == StDone);
  assign Ext_MemWrite  = mem_write_q;
  assign Ext_WriteData = wdata_q;
  assign Ext_DataAdr   = adr_q;
  assign load_err      = load_err_q;

endmodule

// File: doc/uart_mem_loader.md
UART_MEM_LOADER -- requirements
Module: uart_mem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, sets the byte address of word 0.
REQ-002 Parameter MAX_WORDS, default 64, is the largest legal word count; the count register is 16 bits wide.
REQ-003 Parameter TIMEOUT, default 100000, is the maximum number of idle clk cycles allowed between bytes of one frame.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port rx_valid, input, 1 bit: one-cycle strobe from the UART receiver marking that rx_data is valid.
REQ-007 Port rx_data, input, 8 bits: received byte.
REQ-008 Port cpu_reset, output, 1 bit: active-high reset to the CPU top; it also gates the external memory path.
REQ-009 Port Ext_MemWrite, output, 1 bit: word-write strobe to data memory.
REQ-010 Port Ext_WriteData, output, 32 bits: the assembled word.
REQ-011 Port Ext_DataAdr, output, 32 bits: the word byte-address.
REQ-012 Port load_done, output, 1 bit: high once the image is loaded and the CPU is released.
REQ-013 Port load_err, output, 1 bit: sticky flag for an illegal word count.

Function
REQ-014 The frame format SHALL be a 4-byte little-endian word count N followed by N words, each sent as 4 bytes little-endian.
REQ-015 The FSM SHALL have the states HDR, DATA, WRITE, DONE and ERR; the reset state is HDR.
REQ-016 HDR: each rx_valid byte SHALL be shifted into the count register, least-significant byte first, and a byte index SHALL count 0..3.
- On the 4th byte, N=0 SHALL go to DONE.
- On the 4th byte, N>MAX_WORDS SHALL go to ERR.
- Otherwise the FSM SHALL go to DATA with word index 0.
REQ-017 DATA: bytes SHALL be assembled into a 32-bit shift register, LSB first; the 4th byte SHALL go to WRITE on the next edge.
REQ-018 WRITE SHALL last exactly one cycle with:
- Ext_MemWrite=1;
- Ext_WriteData = the assembled word;
- Ext_DataAdr = BASE_ADDR + 4*word_index (32-bit wrap-around).
REQ-019 Leaving WRITE, the word index SHALL increment; the FSM SHALL go to DONE if the incremented index equals N, else back to DATA.
REQ-020 The latency from the rx_valid of a word's 4th byte to the Ext_MemWrite pulse SHALL be exactly 1 cycle.
REQ-021 An rx_valid arriving during the WRITE cycle SHALL be accepted as byte 0 of the next word (no byte loss).
REQ-022 cpu_reset SHALL be 1 in HDR, DATA, WRITE and ERR, and 0 only in DONE.
REQ-023 The first cycle with cpu_reset=0 SHALL be the cycle after the last WRITE.
REQ-024 load_done SHALL equal 1 exactly in DONE.
REQ-025 DONE and ERR SHALL be absorbing until reset; rx_valid SHALL be ignored in both.
REQ-026 In ERR, load_err SHALL be 1 and Ext_MemWrite SHALL be 0.
REQ-027 Outside WRITE, Ext_MemWrite SHALL be 0, and Ext_DataAdr and Ext_WriteData SHALL be 0.
REQ-028 Timeout: when a partial frame is in progress (byte index ≠0 in HDR, or any state in DATA) and TIMEOUT cycles pass without rx_valid:
- the byte index, word index and shift registers SHALL clear;
- the FSM SHALL return to HDR;
- memory already written SHALL NOT be rolled back.
REQ-029 The idle counter SHALL clear on every rx_valid and SHALL saturate, never wrapping.
REQ-030 In HDR with byte index 0, the timeout SHALL NOT fire.

Reset
REQ-031 Asserting reset (0) SHALL immediately, without a clock edge, force:
- state=HDR;
- cpu_reset=1;
- Ext_MemWrite=0, Ext_WriteData=0, Ext_DataAdr=0;
- load_done=0, load_err=0;
- all counters and shift registers to 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame; the next frame SHALL start from its header.
REQ-033 On the first edge after reset release, the block SHALL be ready to accept a byte.

Structure
REQ-034 The state encoding and the header length constant (4) SHALL live in the shared package riscv_pkg.
REQ-035 The block SHALL be a single module with no sub-modules; the idle/timeout counter MAY be an inline always block.
REQ-036 All outputs SHALL be registered, except cpu_reset and load_done, which are decoded from state.

Verification
REQ-037 Reset, then bytes 01 00 00 00 followed by 13 05 A0 00 -> one Ext_MemWrite pulse with Adr=0x0 and Data=0x00A00513; cpu_reset falls 1 cycle later; load_done=1.
REQ-038 N=3 sent with back-to-back rx_valid every cycle -> 3 pulses at Adr 0x0, 0x4 and 0x8 with no dropped byte, including a byte arriving in the WRITE cycle.
REQ-039 Header bytes 00 00 00 00 -> DONE directly, zero writes, cpu_reset=0 the cycle after the 4th byte.
REQ-040 Header N=MAX_WORDS+1 (65) -> ERR, load_err=1, cpu_reset stays 1, further bytes produce no writes.
REQ-041 With TIMEOUT=10: send 2 data bytes, stay idle 10 cycles, then send a fresh header N=1 plus a word -> exactly one write, at Adr=BASE_ADDR.
REQ-042 Assert reset during DATA of word 2 -> all outputs go to reset values asynchronously; a subsequent full frame loads correctly from word 0.
